glove_tracker: RTL and testbench
================================

Name: glove_tracker

Overview:
Conditions one glove's raw tracker data (position samples and hand-closed flag) before it reaches the ball state machine. It smooths position with an exponential moving average, debounces the closed flag, and detects loss of tracking. A cooldown FSM generates can_catch so a glove cannot re-catch immediately after releasing. One instance per glove; outputs drive gloveNx, gloveNy, gloveNclosed and can_catchN.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive cycles a synchronized closed level must differ from glove_closed before glove_closed toggles (10 ms at 27 MHz).
COOLDOWN_CYCLES, 13500000, cycles can_catch stays low after a release (0.5 s).
LOST_CYCLES, 2700000, cycles without raw_valid before track_lost asserts (100 ms).
SMOOTH_SHIFT, 2, EMA weight 1/2^SMOOTH_SHIFT.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
raw_x  in  16  raw glove x, mm, unsigned
raw_y  in  16  raw glove y, mm, unsigned
raw_valid  in  1  one-cycle strobe; raw_x/raw_y are valid
raw_closed  in  1  unsynchronized hand-closed level
glove_x  out  16  smoothed x, mm
glove_y  out  16  smoothed y, mm
glove_closed  out  1  debounced closed level
can_catch  out  1  glove is allowed to catch
track_lost  out  1  no sample within LOST_CYCLES

Behaviour:
- Reset (async, high): glove_x=0, glove_y=0, glove_closed=0, track_lost=1, can_catch=0. Synchronizer flops, debounce counter and lost counter clear; cooldown counter=0; FSM=READY. Reset mid-operation aborts everything immediately, with no clock edge needed.
- Position: updates only on a clock edge with raw_valid=1, and outputs are registered (1-cycle latency).
  - If track_lost=1: glove_x<=raw_x, glove_y<=raw_y (direct load), and track_lost<=0 on the same edge.
  - Otherwise, per axis: diff = {0,raw} - {0,glove} as 17-bit signed, then glove <= glove + (diff >>> SMOOTH_SHIFT), truncated to 16 bits. The arithmetic shift rounds toward -inf. The result always lies between old glove and raw, so no overflow.
  - With no raw_valid, positions hold.
- Lost detection: lost counter clears on raw_valid; otherwise it increments, saturating at LOST_CYCLES. The edge on which it reaches LOST_CYCLES sets track_lost=1. Positions hold while lost. A raw_valid on the same edge wins, so track_lost is 0.
- Debounce:
  - raw_closed passes through a 2-flop synchronizer, giving sync.
  - Counter clears whenever sync==glove_closed and increments while they differ.
  - On the edge where the counter reaches DEBOUNCE_CYCLES, glove_closed toggles and the counter clears.
  - A clean raw change therefore reaches glove_closed DEBOUNCE_CYCLES+2 edges later. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Catch FSM (evaluated on debounced glove_closed):
  - READY: can_catch=1. glove_closed 0->1 goes to HOLDING.
  - HOLDING: can_catch=1. It must stay high here because the consumer registers the close edge 2 cycles late. glove_closed 1->0 goes to COOLDOWN and loads the counter with COOLDOWN_CYCLES-1.
  - COOLDOWN: can_catch=0. Counter decrements each cycle. When it is 0: go to HOLDING if glove_closed=1, else READY. So can_catch is low for exactly COOLDOWN_CYCLES cycles. A close during COOLDOWN does not shorten or restart the count.
  - Override: can_catch is forced 0 whenever track_lost=1. The FSM keeps running underneath.
- can_catch is a registered output, derived from next-state and next-track_lost so it is aligned with the FSM register.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, LOST_CYCLES=20, SMOOTH_SHIFT=2.)
1. Reset, then raw_valid with x=1000, y=2000 -> next edge: glove_x=1000, glove_y=2000, track_lost=0, can_catch=1.
2. Then valid x=1400 -> glove_x=1100. Then valid x=600 -> glove_x=975 (diff -500>>>2 = -125). y=2000 is unchanged throughout.
3. raw_closed high for 3 cycles then low -> glove_closed never rises. raw_closed held high -> glove_closed=1 exactly 6 edges after the raw rise, and can_catch stays 1.
4. Closed, then release -> glove_closed falls, can_catch=0 for exactly 8 cycles, then 1. Re-close at cooldown cycle 3 -> can_catch is still low until cycle 8 and the FSM ends in HOLDING.
5. No raw_valid for 20 cycles -> track_lost=1, can_catch=0, glove_x/glove_y held. Next valid with x=3000 -> glove_x=3000 directly, track_lost=0.
6. Assert reset asynchronously mid-COOLDOWN and mid-debounce -> all outputs take reset values before the next clk edge. After release, the FSM is READY but can_catch=0 until the first raw_valid.

Source files
------------

// File: rtl/glove_tracker.sv
// Per-glove conditioning: EMA-smoothed position, debounced hand-closed level,
// tracking-loss detection and a cooldown FSM that gates can_catch after a release.
module glove_tracker #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int COOLDOWN_CYCLES = 13500000,
    parameter int LOST_CYCLES     = 2700000,
    parameter int SMOOTH_SHIFT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raw_x,
    input  logic [15:0] raw_y,
    input  logic        raw_valid,
    input  logic        raw_closed,
    output logic [15:0] glove_x,
    output logic [15:0] glove_y,
    output logic        glove_closed,
    output logic        can_catch,
    output logic        track_lost,
    output logic [1:0]  fsm_state
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LOST_W = $clog2(LOST_CYCLES + 1);
    localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_CYCLES);
    localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        READY    = 2'd0,
        HOLDING  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    logic signed [16:0] diff_x, diff_y, step_x, step_y;
    logic [LOST_W-1:0]  lost_cnt;
    logic               next_lost;
    logic               sync_meta, sync_level;
    logic [DEB_W-1:0]   deb_cnt;
    state_t             state, next_state;
    logic [CD_W-1:0]    cd_cnt, next_cd;

    // The 17-bit difference keeps the sign; the shifted step never overshoots raw.
    always_comb begin
        diff_x = $signed({1'b0, raw_x}) - $signed({1'b0, glove_x});
        diff_y = $signed({1'b0, raw_y}) - $signed({1'b0, glove_y});
        step_x = diff_x >>> SMOOTH_SHIFT;
        step_y = diff_y >>> SMOOTH_SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glove_x <= '0;
            glove_y <= '0;
        end else if (raw_valid) begin
            if (track_lost) begin
                glove_x <= raw_x;
                glove_y <= raw_y;
            end else begin
                glove_x <= glove_x + step_x[15:0];
                glove_y <= glove_y + step_y[15:0];
            end
        end
    end

    assign next_lost = raw_valid ? 1'b0 : (track_lost || (lost_cnt == LOST_MAX - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_cnt   <= '0;
            track_lost <= 1'b1;
        end else begin
            track_lost <= next_lost;
            if (raw_valid)
                lost_cnt <= '0;
            else if (lost_cnt != LOST_MAX)
                lost_cnt <= lost_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta    <= 1'b0;
            sync_level   <= 1'b0;
            deb_cnt      <= '0;
            glove_closed <= 1'b0;
        end else begin
            sync_meta  <= raw_closed;
            sync_level <= sync_meta;
            if (sync_level == glove_closed) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                glove_closed <= ~glove_closed;
                deb_cnt      <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // HOLDING keeps can_catch high: the consumer sees the close edge two cycles late.
    always_comb begin
        next_state = state;
        next_cd    = cd_cnt;
        case (state)
            READY:    if (glove_closed) next_state = HOLDING;
            HOLDING:  if (!glove_closed) begin
                          next_state = COOLDOWN;
                          next_cd    = CD_LOAD;
                      end
            COOLDOWN: if (cd_cnt == '0) next_state = glove_closed ? HOLDING : READY;
                      else next_cd = cd_cnt - 1'b1;
            default:  next_state = READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= READY;
            cd_cnt    <= '0;
            can_catch <= 1'b0;
        end else begin
            state     <= next_state;
            cd_cnt    <= next_cd;
            can_catch <= (next_state != COOLDOWN) && !next_lost;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_glove_tracker.sv
// Bench for glove_tracker: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the glove conditioning rules.
module tb_glove_tracker;

    localparam int DEB   = 4;
    localparam int COOL  = 8;
    localparam int LOST  = 20;
    localparam int SHIFT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] raw_x, raw_y;
    logic        raw_valid, raw_closed;
    logic [15:0] glove_x, glove_y;
    logic        glove_closed, can_catch, track_lost;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    int m_x, m_y, m_lost, m_idle, m_c, m_run, m_s1, m_s2, m_cc;
    int edge_n, win_start, win_end;
    int pct, hold;

    glove_tracker #(
        .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_CYCLES(COOL),
        .LOST_CYCLES(LOST),
        .SMOOTH_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset),
        .raw_x(raw_x), .raw_y(raw_y), .raw_valid(raw_valid), .raw_closed(raw_closed),
        .glove_x(glove_x), .glove_y(glove_y), .glove_closed(glove_closed),
        .can_catch(can_catch), .track_lost(track_lost), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Moves g one 1/2^SHIFT fraction of the way to r, rounding toward -infinity.
    function automatic int ema(input int g, input int r);
        int d, s, q;
        q = 1 << SHIFT;
        d = r - g;
        if (d >= 0) s = d / q;
        else        s = -((-d + q - 1) / q);
        return g + s;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_lost = 1; m_idle = 0;
        m_c = 0; m_run = 0; m_s1 = 0; m_s2 = 0; m_cc = 0;
        edge_n = 0; win_start = 1; win_end = 0;
    endtask

    task automatic model_step();
        int cprev;
        cprev = m_c;
        edge_n++;
        if (raw_valid) begin
            if (m_lost != 0) begin
                m_x = int'(raw_x); m_y = int'(raw_y);
            end else begin
                m_x = ema(m_x, int'(raw_x)); m_y = ema(m_y, int'(raw_y));
            end
        end
        if (raw_valid) begin
            m_lost = 0; m_idle = 0;
        end else begin
            if (m_idle < LOST) m_idle++;
            if (m_idle == LOST) m_lost = 1;
        end
        // Closed level toggles once the twice-delayed raw level has disagreed for DEB edges.
        if (m_s2 != m_c) begin
            m_run++;
            if (m_run == DEB) begin m_c = 1 - m_c; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(raw_closed);
        // A release outside an active cooldown window opens a new COOL-cycle window.
        if (cprev == 1 && m_c == 0 && edge_n > win_end) begin
            win_start = edge_n + 1;
            win_end   = edge_n + COOL;
        end
        m_cc = (m_lost == 0 && !(edge_n >= win_start && edge_n <= win_end)) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("glove_x", glove_x, m_x);
        chk("glove_y", glove_y, m_y);
        chk("glove_closed", glove_closed, m_c);
        chk("track_lost", track_lost, m_lost);
        chk("can_catch", can_catch, m_cc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, glove_x, 0);
        chk({tag, "_y"}, glove_y, 0);
        chk({tag, "_closed"}, glove_closed, 0);
        chk({tag, "_lost"}, track_lost, 1);
        chk({tag, "_catch"}, can_catch, 0);
        chk({tag, "_state"}, fsm_state, 0);
    endtask

    initial begin
        reset = 1'b1; raw_x = '0; raw_y = '0; raw_valid = 1'b0; raw_closed = 1'b0;
        #2;
        check_reset_values("rst0");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // First sample after reset loads directly.
        raw_valid = 1'b1; raw_x = 16'd1000; raw_y = 16'd2000;
        tick();
        chk("load_x", glove_x, 1000);
        chk("load_y", glove_y, 2000);
        chk("load_lost", track_lost, 0);
        chk("load_catch", can_catch, 1);

        raw_x = 16'd1400;
        tick();
        chk("ema_up", glove_x, 1100);
        raw_x = 16'd600;
        tick();
        chk("ema_down", glove_x, 975);
        chk("ema_y_hold", glove_y, 2000);

        // Keep samples flowing at the current position so tracking stays alive.
        raw_x = 16'd975;

        raw_closed = 1'b1;
        ticks(3);
        raw_closed = 1'b0;
        ticks(8);
        chk("glitch_reject", glove_closed, 0);

        raw_closed = 1'b1;
        ticks(5);
        chk("deb_edge5", glove_closed, 0);
        tick();
        chk("deb_edge6", glove_closed, 1);
        chk("deb_catch", can_catch, 1);
        ticks(3);
        chk("holding", fsm_state, 1);

        raw_closed = 1'b0;
        ticks(6);
        chk("rel_closed", glove_closed, 0);
        chk("rel_catch_f", can_catch, 1);
        for (int i = 0; i < COOL; i++) begin
            tick();
            chk("cool_low", can_catch, 0);
        end
        tick();
        chk("cool_end", can_catch, 1);
        chk("cool_ready", fsm_state, 0);

        // Close, release, then re-close while the cooldown is running.
        raw_closed = 1'b1;
        ticks(8);
        raw_closed = 1'b0;
        ticks(7);
        raw_closed = 1'b1;
        for (int i = 1; i < COOL; i++) begin
            tick();
            chk("reclose_low", can_catch, 0);
        end
        tick();
        chk("reclose_end", can_catch, 1);
        chk("reclose_hold", fsm_state, 1);
        chk("reclose_closed", glove_closed, 1);

        raw_valid = 1'b0;
        ticks(LOST - 1);
        chk("lost_pre", track_lost, 0);
        tick();
        chk("lost_set", track_lost, 1);
        chk("lost_catch", can_catch, 0);
        chk("lost_hold_x", glove_x, 975);
        raw_valid = 1'b1; raw_x = 16'd3000; raw_y = 16'd500;
        tick();
        chk("relock_x", glove_x, 3000);
        chk("relock_y", glove_y, 500);
        chk("relock_lost", track_lost, 0);

        hold = 0;
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 60 : ((seg % 3 == 1) ? 15 : 2);
            for (int i = 0; i < 100; i++) begin
                if (hold == 0) begin
                    raw_closed = 1'($urandom_range(0, 1));
                    hold = $urandom_range(1, 12);
                end
                hold--;
                raw_valid = ($urandom_range(0, 99) < pct);
                raw_x = 16'($urandom);
                raw_y = 16'($urandom);
                tick();
            end
        end

        // Asynchronous reset while cooling down and mid-debounce.
        raw_valid = 1'b1; raw_x = 16'd1234; raw_y = 16'd4321;
        raw_closed = 1'b0;
        ticks(24);
        raw_closed = 1'b1;
        ticks(8);
        raw_closed = 1'b0;
        ticks(9);
        chk("mid_cool", fsm_state, 2);
        raw_closed = 1'b1;
        ticks(3);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("rst_async");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; raw_closed = 1'b0; raw_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_ready", fsm_state, 0);
            chk("post_rst_catch", can_catch, 0);
        end
        raw_valid = 1'b1; raw_x = 16'd77; raw_y = 16'd88;
        tick();
        chk("post_rst_load", glove_x, 77);
        chk("post_rst_catch1", can_catch, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
